// File: rtl/bcd_addsub_ctrl.sv
// rtl/bcd_addsub_ctrl.sv - signed BCD add/subtract sequencer over a shared digit adder
// A single bcd_adder is reused for the main pass and the complement-fixup pass.

module bcd_adder #(
  parameter int NUM_DIGITS = 8
) (
  input  logic [NUM_DIGITS*4-1:0] a,
  input  logic [NUM_DIGITS*4-1:0] b,
  input  logic                    cin,
  output logic [NUM_DIGITS*4-1:0] sum,
  output logic                    cout
);
  logic       c;
  logic [4:0] s;

  always_comb begin
    c   = cin;
    s   = '0;
    sum = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      s = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0, c};
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      sum[i*4 +: 4] = s[3:0];
    end
    cout = c;
  end
endmodule

module bcd_addsub_ctrl #(
  parameter int NUM_DIGITS = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_op,
  input  logic                    i_sign_a,
  input  logic [NUM_DIGITS*4-1:0] i_num_a,
  input  logic                    i_sign_b,
  input  logic [NUM_DIGITS*4-1:0] i_num_b,
  output logic [NUM_DIGITS*4-1:0] o_num,
  output logic                    o_sign,
  output logic                    o_overflow,
  output logic                    o_busy,
  output logic                    o_done
);
  localparam int W = NUM_DIGITS * 4;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t         state, state_next;
  logic [W-1:0]   a_reg, b_reg, hold_reg;
  logic           sign_a_reg, sign_b_reg;
  logic           is_add;
  logic [W-1:0]   add_a, add_b, add_sum;
  logic           add_cin, add_cout;
  logic           sum_zero;

  function automatic logic [W-1:0] nines(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) r[i*4 +: 4] = 4'd9 - v[i*4 +: 4];
    return r;
  endfunction

  assign is_add   = (sign_a_reg == sign_b_reg);
  assign sum_zero = (add_sum == '0);
  assign o_busy   = (state != IDLE);
  assign o_done   = (state == DONE);

  // Subtraction is A + 9s(B) + 1; a missing carry means A<B and the sum is re-complemented.
  always_comb begin
    add_a   = a_reg;
    add_b   = b_reg;
    add_cin = 1'b0;
    case (state)
      PASS1: begin
        if (!is_add) begin
          add_b   = nines(b_reg);
          add_cin = 1'b1;
        end
      end
      PASS2: begin
        add_a   = '0;
        add_b   = nines(hold_reg);
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  bcd_adder #(.NUM_DIGITS(NUM_DIGITS)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = PASS1;
      PASS1:   state_next = (is_add || add_cout) ? DONE : PASS2;
      PASS2:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      hold_reg   <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      o_num      <= '0;
      o_sign     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            a_reg      <= i_num_a;
            b_reg      <= i_num_b;
            sign_a_reg <= i_sign_a;
            sign_b_reg <= i_sign_b ^ i_op;
          end
        end
        PASS1: begin
          if (is_add || add_cout) begin
            o_num      <= add_sum;
            o_overflow <= is_add ? add_cout : 1'b0;
            o_sign     <= sum_zero ? 1'b0 : sign_a_reg;
          end else begin
            hold_reg <= add_sum;
            o_sign   <= ~sign_a_reg;
          end
        end
        PASS2: begin
          o_num      <= add_sum;
          o_overflow <= 1'b0;
          if (sum_zero) o_sign <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/bcd_addsub_ctrl.md
Name: bcd_addsub_ctrl

Overview:
- Sequencer for signed decimal add/subtract in the RPN calculator datapath.
- Owns one bcd_adder instance of width NUM_DIGITS and time-multiplexes it over one or two passes.
- Takes sign-magnitude BCD operands and an opcode; produces a sign-magnitude BCD result with an overflow flag.
- Uses a start/busy/done handshake toward the calculator core FSM.

Parameters:
NUM_DIGITS, 8, number of BCD digits per magnitude (operand and result width = NUM_DIGITS*4 bits)

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  synchronous active-high reset
i_start  input  1  request operation; sampled only in IDLE
i_op  input  1  0 = A+B, 1 = A-B
i_sign_a  input  1  sign of A (1 = negative)
i_num_a  input  NUM_DIGITS*4  magnitude of A, packed BCD
i_sign_b  input  1  sign of B
i_num_b  input  NUM_DIGITS*4  magnitude of B, packed BCD
o_num  output  NUM_DIGITS*4  result magnitude, packed BCD
o_sign  output  1  result sign
o_overflow  output  1  magnitude exceeded NUM_DIGITS digits (addition path only)
o_busy  output  1  operation in progress
o_done  output  1  one-cycle pulse when result valid

Behaviour:
- Clocking and reset: one clock i_clk; reset i_rst is synchronous, active-high.
- Reset values: state=IDLE, o_num=0, o_sign=0, o_overflow=0, o_busy=0, o_done=0.
- Reset mid-operation aborts to IDLE with the above values; no o_done is issued.
- Operand capture: on a clock edge in IDLE with i_start=1, register A, B, sign_a and eff_sign_b = i_sign_b ^ i_op; go to PASS1.
- Captured operands are held internally; input ports may change freely after capture.
- i_start is ignored in every state other than IDLE.
- Operation selection: if sign_a == eff_sign_b, the operation is ADD, otherwise SUB.
- PASS1, ADD:
  - Adder inputs: a=A, b=B, carry=0.
  - On the next edge: o_num <= sum, o_overflow <= carry-out, o_sign <= sign_a; go to DONE.
- PASS1, SUB:
  - Adder inputs: a=A, b=nines-complement(B) (each digit 9-d), carry=1.
  - Carry-out=1 (A>=B): o_num <= sum, o_sign <= sign_a, o_overflow <= 0; go to DONE.
  - Carry-out=0 (A<B): hold sum internally, o_sign <= ~sign_a; go to PASS2.
- PASS2 (SUB fixup):
  - Adder inputs: a=0, b=nines-complement(held sum), carry=1.
  - On the next edge: o_num <= sum, o_overflow <= 0; go to DONE.
  - The carry-out of this pass is ignored.
- Zero rule: whenever the value written to o_num is all zero, o_sign is forced to 0. This holds in every path, including ADD with overflow wrapping to zero.
- DONE: o_done=1 for exactly this one cycle, then IDLE.
  - i_start in the DONE cycle is ignored.
  - A new operation can be accepted from the cycle after DONE.
- o_busy: 1 in PASS1, PASS2 and DONE; 0 in IDLE.
- Latency: i_start sampled at edge k gives o_done high in cycle k+2 (ADD, or SUB with A>=B) or in cycle k+3 (SUB with A<B).
- Output holding: o_num, o_sign and o_overflow hold their values from DONE until the next PASS1/PASS2 write or reset.
- Overflow: o_num holds the low NUM_DIGITS digits (wrap-around) and o_sign follows the ADD rule.
- Inputs must be valid BCD (digits 0-9). Results for non-BCD digits are unspecified but must not hang the FSM.
- bcd_adder is combinational; the only registers are the FSM, the operand/intermediate registers and the output registers.

Test Plan:
1. A=+60000000, op=add, B=+29999999 -> o_num=89999999, o_sign=0, o_overflow=0; o_done exactly 2 cycles after i_start edge, o_busy high 2 cycles.
2. A=+00000005, op=sub, B=+00000012 -> PASS2 taken, o_num=00000007, o_sign=1, o_overflow=0; o_done 3 cycles after start.
3. A=+99999999, op=add, B=+00000001 -> o_num=00000000, o_overflow=1, o_sign=0; A=-00000003 sub B=-00000004 -> o_num=00000001, o_sign=0.
4. A=-00000042, op=add, B=+00000042 -> o_num=00000000, o_sign=0 (zero rule), no PASS2; A=+00000003 sub B=-00000004 -> ADD path, o_num=00000007, o_sign=0.
5. Handshake checks:
   - i_start held high continuously gives one operation per 3-cycle (or 4-cycle) window, with no acceptance while o_busy=1.
   - Changing operands during busy does not alter the result.
6. Reset in PASS1 and, separately, in PASS2 -> next cycle all outputs 0, state IDLE, no o_done pulse; the following operation (case 1) completes correctly.
